// File: rtl/morty_clint.sv
// Core-local interruptor: msip, mtimecmp and a prescaled 64-bit mtime behind a
// Wishbone slave that answers every request one cycle later with ack or err.
module morty_clint #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_addr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } reg_sel_e;

    reg_sel_e    reg_sel;
    logic        req;
    logic        mapped;
    logic        wr;
    logic        tick;
    logic [31:0] rdata;
    logic [63:0] mtime, mtime_next;
    logic [63:0] mtimecmp, mtimecmp_next;
    logic        msip, msip_next;
    logic [15:0] presc, presc_next;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^wb_addr_i[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

    // A request is only accepted while no response is on the bus, which
    // spaces back-to-back strobes to one transfer every second cycle.
    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign mapped = (reg_sel != SEL_NONE);
    assign wr     = req & wb_we_i;
    assign tick   = (presc == DIV_LAST);

    always_comb begin
        unique case (wb_addr_i[15:2])
            14'h0000: reg_sel = SEL_MSIP;
            14'h1000: reg_sel = SEL_CMP_LO;
            14'h1001: reg_sel = SEL_CMP_HI;
            14'h2FFE: reg_sel = SEL_TIME_LO;
            14'h2FFF: reg_sel = SEL_TIME_HI;
            default:  reg_sel = SEL_NONE;
        endcase
    end

    always_comb begin
        case (reg_sel)
            SEL_MSIP:    rdata = {31'd0, msip};
            SEL_CMP_LO:  rdata = mtimecmp[31:0];
            SEL_CMP_HI:  rdata = mtimecmp[63:32];
            SEL_TIME_LO: rdata = mtime[31:0];
            SEL_TIME_HI: rdata = mtime[63:32];
            default:     rdata = 32'd0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        mtime_next    = mtime;
        mtimecmp_next = mtimecmp;
        msip_next     = msip;
        presc_next    = tick ? 16'd0 : presc + 16'd1;

        // An mtime write in a tick cycle replaces that cycle's increment.
        if (wr && reg_sel == SEL_TIME_LO) begin
            mtime_next[31:0] = merge_bytes(mtime[31:0], wb_dat_i, wb_sel_i);
        end else if (wr && reg_sel == SEL_TIME_HI) begin
            mtime_next[63:32] = merge_bytes(mtime[63:32], wb_dat_i, wb_sel_i);
        end else if (tick) begin
            mtime_next = mtime + 64'd1;
        end

        if (wr && reg_sel == SEL_CMP_LO)
            mtimecmp_next[31:0] = merge_bytes(mtimecmp[31:0], wb_dat_i, wb_sel_i);
        if (wr && reg_sel == SEL_CMP_HI)
            mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], wb_dat_i, wb_sel_i);
        if (wr && reg_sel == SEL_MSIP && wb_sel_i[0])
            msip_next = wb_dat_i[0];
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, which is what read capture relies on.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime       <= 64'd0;
            mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip        <= 1'b0;
            presc       <= 16'd0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= 32'd0;
            xint_mtip_o <= 1'b0;
        end else begin
            mtime       <= mtime_next;
            mtimecmp    <= mtimecmp_next;
            msip        <= msip_next;
            presc       <= presc_next;
            wb_ack_o    <= req & mapped;
            wb_err_o    <= req & ~mapped;
            wb_dat_o    <= (req && !wb_we_i && mapped) ? rdata : 32'd0;
            xint_mtip_o <= (mtime >= mtimecmp);
        end
    end

    assign xint_msip_o = msip;

endmodule

// File: tb/tb_morty_clint.sv
// Directed bench for morty_clint: instance a runs TICK_DIV=1, instance b TICK_DIV=4.
module tb_morty_clint;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0, rst_b = 1'b0;
    logic        cyc_a = 0, stb_a = 0, we_a = 0;
    logic        cyc_b = 0, stb_b = 0, we_b = 0;
    logic [15:0] addr_a = 0, addr_b = 0;
    logic [3:0]  sel_a = 0, sel_b = 0;
    logic [31:0] wdat_a = 0, wdat_b = 0;
    logic [31:0] rdat_a, rdat_b;
    logic        ack_a, err_a, mtip_a, msip_a;
    logic        ack_b, err_b, mtip_b, msip_b;

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    morty_clint #(.TICK_DIV(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .wb_cyc_i(cyc_a), .wb_stb_i(stb_a),
        .wb_we_i(we_a), .wb_addr_i(addr_a), .wb_sel_i(sel_a), .wb_dat_i(wdat_a),
        .wb_dat_o(rdat_a), .wb_ack_o(ack_a), .wb_err_o(err_a),
        .xint_mtip_o(mtip_a), .xint_msip_o(msip_a)
    );

    morty_clint #(.TICK_DIV(4)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .wb_cyc_i(cyc_b), .wb_stb_i(stb_b),
        .wb_we_i(we_b), .wb_addr_i(addr_b), .wb_sel_i(sel_b), .wb_dat_i(wdat_b),
        .wb_dat_o(rdat_b), .wb_ack_o(ack_b), .wb_err_o(err_b),
        .xint_mtip_o(mtip_b), .xint_msip_o(msip_b)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic we, logic [15:0] addr, logic [3:0] sel,
                                 logic [31:0] wd, logic exp_ack, logic exp_err,
                                 logic chk_rd, logic [31:0] exp_rd);
        vec_t v;
        v.we = we; v.addr = addr; v.sel = sel; v.wd = wd;
        v.exp_ack = exp_ack; v.exp_err = exp_err; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic resp_busy(int dut);
        return (dut == 0) ? (ack_a | err_a) : (ack_b | err_b);
    endfunction

    // One transfer, started from idle so the response lands on the next edge.
    // phase >= 0 delays the request until the commit edge index mod 4 equals it.
    task automatic bus(input int dut, input logic we, input logic [15:0] addr,
                       input logic [3:0] sel, input logic [31:0] wd, input int phase,
                       output logic [31:0] rd, output logic ack, output logic err,
                       output int edge_n);
        logic got;
        @(negedge clk);
        while (resp_busy(dut)) @(negedge clk);
        if (phase >= 0) while (((ecount + 1) % 4) != phase) @(negedge clk);
        if (dut == 0) begin
            cyc_a = 1; stb_a = 1; we_a = we; addr_a = addr; sel_a = sel; wdat_a = wd;
        end else begin
            cyc_b = 1; stb_b = 1; we_b = we; addr_b = addr; sel_b = sel; wdat_b = wd;
        end
        rd = 0; ack = 0; err = 0; edge_n = -1; got = 0;
        for (int i = 0; i < 3 && !got; i++) begin
            @(posedge clk); #1;
            if (resp_busy(dut)) begin
                got = 1;
                edge_n = ecount;
                if (dut == 0) begin rd = rdat_a; ack = ack_a; err = err_a; end
                else          begin rd = rdat_b; ack = ack_b; err = err_b; end
            end
        end
        if (dut == 0) begin cyc_a = 0; stb_a = 0; we_a = 0; end
        else          begin cyc_b = 0; stb_b = 0; we_b = 0; end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_timeout: got no response, expected ack or err at 0x%h", addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        ack, err, found;
        int          e, ew, ec, et;
        logic [63:0] v;

        vecs.push_back(mkv(1, 16'h4000, 4'b0010, 32'hAABB_CCDD, 1, 0, 0, 32'h0));
        vecs.push_back(mkv(0, 16'h4000, 4'b1111, 32'h0,         1, 0, 1, 32'hFFFF_CCFF));
        vecs.push_back(mkv(0, 16'h4004, 4'b1111, 32'h0,         1, 0, 1, 32'hFFFF_FFFF));
        vecs.push_back(mkv(1, 16'h4004, 4'b1111, 32'h1234_5678, 1, 0, 0, 32'h0));
        vecs.push_back(mkv(0, 16'h4004, 4'b1111, 32'h0,         1, 0, 1, 32'h1234_5678));
        vecs.push_back(mkv(1, 16'h4007, 4'b1001, 32'hAA00_00BB, 1, 0, 0, 32'h0));
        vecs.push_back(mkv(0, 16'h4004, 4'b1111, 32'h0,         1, 0, 1, 32'hAA34_56BB));
        vecs.push_back(mkv(0, 16'h0008, 4'b1111, 32'h0,         0, 1, 1, 32'h0));
        vecs.push_back(mkv(1, 16'h0008, 4'b1111, 32'hFFFF_FFFF, 0, 1, 1, 32'h0));
        vecs.push_back(mkv(1, 16'h4008, 4'b1111, 32'h0,         0, 1, 1, 32'h0));
        vecs.push_back(mkv(0, 16'h0000, 4'b1111, 32'h0,         1, 0, 1, 32'h0));
        vecs.push_back(mkv(1, 16'h0000, 4'b0001, 32'h0000_0003, 1, 0, 0, 32'h0));
        vecs.push_back(mkv(0, 16'h0000, 4'b1111, 32'h0,         1, 0, 1, 32'h1));
        vecs.push_back(mkv(1, 16'h0000, 4'b1110, 32'h0,         1, 0, 0, 32'h0));
        vecs.push_back(mkv(0, 16'h0000, 4'b1111, 32'h0,         1, 0, 1, 32'h1));
        vecs.push_back(mkv(1, 16'h0000, 4'b0001, 32'h0,         1, 0, 0, 32'h0));
        vecs.push_back(mkv(0, 16'h0000, 4'b1111, 32'h0,         1, 0, 1, 32'h0));
        vecs.push_back(mkv(0, 16'hBFF4, 4'b1111, 32'h0,         0, 1, 1, 32'h0));
        vecs.push_back(mkv(0, 16'h4000, 4'b1111, 32'h0,         1, 0, 1, 32'hFFFF_CCFF));

        // Reset values, asserted asynchronously before any clock edge.
        #2 rst_a = 1; rst_b = 1;
        #1;
        check("reset_a_outputs", {rdat_a, ack_a, err_a, mtip_a, msip_a}, 64'd0);
        check("reset_b_outputs", {rdat_b, ack_b, err_b, mtip_b, msip_b}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_a = 0; rst_b = 0;

        // Register table on instance b.
        foreach (vecs[i]) begin
            bus(1, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wd, -1, rd, ack, err, e);
            check($sformatf("vec%0d_ack", i), ack, vecs[i].exp_ack);
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // Software interrupt on instance a.
        bus(0, 1, 16'h0000, 4'hF, 32'hFFFF_FFFF, -1, rd, ack, err, e);
        check("msip_set_on_ack", msip_a, 1);
        bus(0, 0, 16'h0000, 4'hF, 32'h0, -1, rd, ack, err, e);
        check("msip_read", rd, 32'h1);
        bus(0, 1, 16'h0000, 4'hF, 32'h0, -1, rd, ack, err, e);
        check("msip_clear_on_ack", msip_a, 0);

        // Timer compare at TICK_DIV=1: mtime=0 right after edge ew.
        bus(0, 1, 16'h4004, 4'hF, 32'd0, -1, rd, ack, err, e);
        bus(0, 1, 16'h4000, 4'hF, 32'd20, -1, rd, ack, err, e);
        bus(0, 1, 16'hBFFC, 4'hF, 32'd0, -1, rd, ack, err, e);
        bus(0, 1, 16'hBFF8, 4'hF, 32'd0, -1, rd, ack, err, ew);
        repeat (20) @(posedge clk);
        #1 check("mtip_before_20", mtip_a, 0);
        @(posedge clk); #1 check("mtip_rises", mtip_a, 1);
        repeat (3) @(posedge clk);
        #1 check("mtip_stays", mtip_a, 1);
        bus(0, 1, 16'h4004, 4'hF, 32'd1, -1, rd, ack, err, e);
        @(posedge clk); #1 check("mtip_drops_after_cmp_hi", mtip_a, 0);

        // Carry from low to high word.
        bus(0, 1, 16'hBFFC, 4'hF, 32'd0, -1, rd, ack, err, e);
        bus(0, 1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF, -1, rd, ack, err, ew);
        v = 64'h0000_0000_FFFF_FFFF;
        bus(0, 0, 16'hBFFC, 4'hF, 32'd0, -1, rd, ack, err, e);
        check("carry_hi", rd, 32'(64'(v + 64'(e - 1 - ew)) >> 32));
        check("carry_hi_is_1", rd, 32'd1);
        bus(0, 0, 16'hBFF8, 4'hF, 32'd0, -1, rd, ack, err, e);
        check("carry_lo", rd, 32'(v + 64'(e - 1 - ew)));

        // Wrap from 2^64-1 to 0.
        bus(0, 1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF, -1, rd, ack, err, e);
        bus(0, 1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF, -1, rd, ack, err, ew);
        v = 64'hFFFF_FFFF_FFFF_FFFF;
        bus(0, 0, 16'hBFFC, 4'hF, 32'd0, -1, rd, ack, err, e);
        check("wrap_hi", rd, 32'(64'(v + 64'(e - 1 - ew)) >> 32));
        bus(0, 0, 16'hBFF8, 4'hF, 32'd0, -1, rd, ack, err, e);
        check("wrap_lo", rd, 32'(v + 64'(e - 1 - ew)));

        // Continuous strobe: responses on alternate edges.
        @(negedge clk); @(negedge clk);
        cyc_a = 1; stb_a = 1; we_a = 0; addr_a = 16'h0000; sel_a = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("stream_ack%0d", i), ack_a, (i % 2 == 0));
        end
        check("stream_no_err", err_a, 0);
        cyc_a = 0; stb_a = 0;

        // Asynchronous reset with mtip=1 and a write in flight.
        bus(0, 1, 16'h4004, 4'hF, 32'd0, -1, rd, ack, err, e);
        bus(0, 1, 16'h4000, 4'hF, 32'd0, -1, rd, ack, err, e);
        bus(0, 1, 16'h0000, 4'hF, 32'd1, -1, rd, ack, err, e);
        repeat (2) @(posedge clk);
        #1 check("pre_reset_mtip", mtip_a, 1);
        check("pre_reset_msip", msip_a, 1);
        @(negedge clk);
        cyc_a = 1; stb_a = 1; we_a = 1; addr_a = 16'h4000; sel_a = 4'hF; wdat_a = 32'd5;
        #2 rst_a = 1;
        #1 check("async_reset_outputs", {rdat_a, ack_a, err_a, mtip_a, msip_a}, 64'd0);
        @(posedge clk); #1 check("abort_no_ack", ack_a, 0);
        cyc_a = 0; stb_a = 0; we_a = 0;
        @(negedge clk); rst_a = 0;
        bus(0, 0, 16'h4000, 4'hF, 32'd0, -1, rd, ack, err, e);
        check("post_reset_cmp_lo", rd, 32'hFFFF_FFFF);
        bus(0, 0, 16'h4004, 4'hF, 32'd0, -1, rd, ack, err, e);
        check("post_reset_cmp_hi", rd, 32'hFFFF_FFFF);
        bus(0, 0, 16'h0000, 4'hF, 32'd0, -1, rd, ack, err, e);
        check("post_reset_msip", rd, 32'd0);
        bus(0, 0, 16'hBFFC, 4'hF, 32'd0, -1, rd, ack, err, e);
        check("post_reset_mtime_hi", rd, 32'd0);
        bus(0, 0, 16'hBFF8, 4'hF, 32'd0, -1, rd, ack, err, e);
        check("post_reset_mtime_lo_small", (rd < 32'd16), 1);
        check("post_reset_mtip", mtip_a, 0);

        // Prescaler on instance b: mtimecmp=1, mtime=0, then find a tick edge via mtip.
        bus(1, 1, 16'h4004, 4'hF, 32'd0, -1, rd, ack, err, e);
        bus(1, 1, 16'h4000, 4'hF, 32'd1, -1, rd, ack, err, e);
        bus(1, 1, 16'hBFFC, 4'hF, 32'd0, -1, rd, ack, err, e);
        bus(1, 1, 16'hBFF8, 4'hF, 32'd0, -1, rd, ack, err, ew);
        @(posedge clk); #1 check("div4_mtip_clear", mtip_b, 0);
        found = 0; et = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(posedge clk); #1;
            if (mtip_b) begin found = 1; et = ecount - 1; end
        end
        check("div4_tick_within_4", found, 1);
        for (int i = 0; i < 3; i++) begin
            bus(1, 0, 16'hBFF8, 4'hF, 32'd0, -1, rd, ack, err, e);
            check($sformatf("div4_count%0d", i), rd,
                  (e - 1 >= et) ? 32'((e - 1 - et) / 4 + 1) : 32'd0);
        end

        // Collision: mtime_lo write committed on a tick edge.
        bus(1, 1, 16'hBFF8, 4'hF, 32'd100, et % 4, rd, ack, err, ec);
        for (int i = 0; i < 3; i++) begin
            bus(1, 0, 16'hBFF8, 4'hF, 32'd0, -1, rd, ack, err, e);
            check($sformatf("collision_read%0d", i), rd, 32'(100 + (e - 1 - ec) / 4));
        end
        check("collision_final_101", rd, 32'd101);
        bus(1, 0, 16'hBFFC, 4'hF, 32'd0, -1, rd, ack, err, e);
        check("collision_hi", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
